// File: rtl/sap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap_pkg : shared types and default widths for the SAP memory loader   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package sap_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int OPCODE_W   = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/sap_stack_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap_stack_ptr : downward-growing stack pointer, occupancy, sticky err |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sap_stack_ptr #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int STACK_TOP   = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_inc,
  output logic              do_push,
  output logic              do_pop,
  output logic              do_swap,
  output logic              empty,
  output logic              full,
  output logic              err
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(STACK_TOP);

  logic [CW-1:0] count;

  assign empty   = (count == '0);
  assign full    = (count == CW'(STACK_DEPTH));
  assign sp_inc  = sp + ADDR_W'(1);
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  // Simultaneous push/pop swaps the top entry in place; SP and count stay.
  assign do_swap = push & pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp    <= SP_INIT;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push) begin
        sp    <= sp - ADDR_W'(1);
        count <= count + CW'(1);
      end else if (do_pop) begin
        sp    <= sp_inc;
        count <= count - CW'(1);
      end
      if ((push & ~pop & full) | (pop & empty))
        err <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/sap_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap_mem_loader : unified program/data memory with load port and stack |
// | Optional MEM_CLEAR_EN: zero the whole array after reset.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sap_mem_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STACK_DEPTH = 4,
  parameter int STACK_TOP   = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;

  state_t            state, state_next, mode_state;
  logic              run, boot, clr_done;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sp, sp_inc;
  logic              st_push, st_pop, st_swap;

  assign mode_state = load_mode ? LOAD : RUN;

`ifdef MEM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  logic [ADDR_W-1:0] clr_addr;

  assign boot     = 1'b0;
  assign clr_done = &clr_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
  end
`else
  // One-cycle flag after reset release so the first mode decision is taken
  // without passing through a CLEAR state.
  localparam state_t RESET_STATE = RUN;
  logic boot_r;

  assign boot     = boot_r;
  assign clr_done = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) boot_r <= 1'b1;
    else        boot_r <= 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RESET_STATE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    busy       = 1'b1;
    run        = 1'b0;
    if (boot) begin
      state_next = mode_state;
    end else begin
      case (state)
        LOAD: begin
          load_ready = 1'b1;
          if (!load_mode) state_next = RUN;
        end
        RUN: begin
          busy = 1'b0;
          run  = 1'b1;
          if (load_mode) state_next = LOAD;
        end
        default: begin
          if (clr_done) state_next = mode_state;
        end
      endcase
    end
  end

  sap_stack_ptr #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .STACK_TOP   (STACK_TOP)
  ) u_stack_ptr (
    .clk     (clk),
    .reset   (reset),
    .push    (run & push),
    .pop     (run & pop),
    .sp      (sp),
    .sp_inc  (sp_inc),
    .do_push (st_push),
    .do_pop  (st_pop),
    .do_swap (st_swap),
    .empty   (stack_empty),
    .full    (stack_full),
    .err     (stack_err)
  );

  // Later assignments win, so stack writes override a colliding CPU write.
  always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_EN
    if (state == CLEAR) mem[clr_addr] <= '0;
`endif
    if (load_ready && load_valid) mem[load_addr] <= load_data;
    if (run && cpu_wr_en)         mem[cpu_addr]  <= cpu_wr_data;
    if (st_push)                  mem[sp]        <= push_data;
    if (st_swap)                  mem[sp_inc]    <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rd_data <= '0;
      pop_data    <= '0;
    end else begin
      if (run && cpu_rd_en)  cpu_rd_data <= mem[cpu_addr];
      if (st_pop || st_swap) pop_data    <= mem[sp_inc];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sap_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sap_mem_loader : scoreboard bench for load, CPU access and stack   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sap_mem_loader;
`ifdef MEM_CLEAR_EN
  localparam int         INIT_CYC = 16;
  localparam logic [7:0] EXP_9    = 8'h00;
  localparam logic [7:0] EXP_B    = 8'h00;
`else
  localparam int         INIT_CYC = 1;
  localparam logic [7:0] EXP_9    = 8'h01;
  localparam logic [7:0] EXP_B    = 8'h05;
`endif

  logic       clk = 1'b0;
  logic       reset, load_mode, load_valid, load_ready;
  logic [3:0] load_addr, cpu_addr;
  logic [7:0] load_data, cpu_wr_data, cpu_rd_data, push_data, pop_data;
  logic       cpu_rd_en, cpu_wr_en, push, pop;
  logic       stack_empty, stack_full, stack_err, busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd_q[$];
  logic [7:0] pop_q[$];

  always #5 clk = ~clk;

  sap_mem_loader dut (
    .clk(clk), .reset(reset), .load_mode(load_mode), .load_valid(load_valid),
    .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .push(push), .pop(pop),
    .push_data(push_data), .pop_data(pop_data), .stack_empty(stack_empty),
    .stack_full(stack_full), .stack_err(stack_err), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    if (rd_q.size() > 0)  check_eq("rd_data", {24'h0, cpu_rd_data}, {24'h0, rd_q.pop_front()});
    if (pop_q.size() > 0) check_eq("pop_data", {24'h0, pop_data}, {24'h0, pop_q.pop_front()});
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    cpu_rd_en = 1'b1; cpu_addr = a; rd_q.push_back(exp);
    step();
    cpu_rd_en = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1; push_data = d;
    step();
    push = 1'b0;
  endtask

  task automatic do_pop(input logic [7:0] exp);
    pop = 1'b1; pop_q.push_back(exp);
    step();
    pop = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rd"},    {24'h0, cpu_rd_data}, 32'h0);
    check_eq({tag, "_pop"},   {24'h0, pop_data},    32'h0);
    check_eq({tag, "_ready"}, {31'h0, load_ready},  32'h0);
    check_eq({tag, "_empty"}, {31'h0, stack_empty}, 32'h1);
    check_eq({tag, "_full"},  {31'h0, stack_full},  32'h0);
    check_eq({tag, "_err"},   {31'h0, stack_err},   32'h0);
    check_eq({tag, "_busy"},  {31'h0, busy},        32'h1);
  endtask

  initial begin
    int n;
    reset = 1'b0; load_mode = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    push = 1'b0; pop = 1'b0; push_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    n = 0;
    while (!load_ready && n < 100) begin step(); n++; end
    check_eq("init_cyc", n, INIT_CYC);
    check_eq("load_busy", {31'h0, busy}, 32'h1);

    // Program load, including a rewrite of Bh where the last word wins.
    load_word(4'h9, 8'h01);
    load_word(4'hA, 8'h08);
    load_word(4'h0, 8'h79);
    load_word(4'hB, 8'h5A);
    load_word(4'hB, 8'hC3);

    // CPU and stack requests are ignored while loading.
    cpu_rd_en = 1'b1; cpu_addr = 4'h9; push = 1'b1; push_data = 8'hEE;
    step();
    cpu_rd_en = 1'b0; push = 1'b0;
    check_eq("load_rd_hold", {24'h0, cpu_rd_data}, 32'h0);
    check_eq("load_push_ign", {31'h0, stack_empty}, 32'h1);

    load_mode = 1'b0;
    step();
    check_eq("run_busy", {31'h0, busy}, 32'h0);
    check_eq("run_ready", {31'h0, load_ready}, 32'h0);

    rd(4'h9, 8'h01);
    rd(4'hA, 8'h08);
    rd(4'h0, 8'h79);

    // Same-cycle read and write of Bh returns the old word.
    cpu_wr_en = 1'b1; cpu_wr_data = 8'h05;
    rd(4'hB, 8'hC3);
    cpu_wr_en = 1'b0;
    rd(4'hB, 8'h05);
    step();
    check_eq("rd_hold", {24'h0, cpu_rd_data}, 32'h05);

    // Push and pop together swap the top entry.
    do_push(8'h04);
    push = 1'b1; push_data = 8'h06; pop = 1'b1; pop_q.push_back(8'h04);
    step();
    push = 1'b0; pop = 1'b0;
    check_eq("swap_empty", {31'h0, stack_empty}, 32'h0);
    check_eq("swap_full", {31'h0, stack_full}, 32'h0);
    do_pop(8'h06);
    check_eq("swap_done_empty", {31'h0, stack_empty}, 32'h1);
    check_eq("swap_err", {31'h0, stack_err}, 32'h0);

    // Underflow: pop_data holds, error is sticky.
    pop = 1'b1;
    step();
    pop = 1'b0;
    check_eq("uf_err", {31'h0, stack_err}, 32'h1);
    check_eq("uf_pop_hold", {24'h0, pop_data}, 32'h06);
    repeat (3) step();
    check_eq("uf_err_sticky", {31'h0, stack_err}, 32'h1);

    // Asynchronous reset with a CPU write in flight.
    cpu_wr_en = 1'b1; cpu_addr = 4'h9; cpu_wr_data = 8'hFF;
    #2 reset = 1'b0;
    #1 check_reset_vals("midrst");
    cpu_wr_en = 1'b0;
    step();
    step();
    reset = 1'b1;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    check_eq("rst_busy_cyc", n, INIT_CYC);
`ifdef MEM_CLEAR_EN
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00);
`else
    rd(4'h9, EXP_9);
`endif

    // Fill, overflow, then drain in LIFO order.
    do_push(8'h03);
    do_push(8'h07);
    do_push(8'h01);
    do_push(8'h02);
    check_eq("fill_full", {31'h0, stack_full}, 32'h1);
    check_eq("fill_err", {31'h0, stack_err}, 32'h0);
    do_push(8'h09);
    check_eq("of_err", {31'h0, stack_err}, 32'h1);
    rd(4'hB, EXP_B);
    rd(4'hC, 8'h02);
    do_pop(8'h02);
    do_pop(8'h01);
    do_pop(8'h07);
    do_pop(8'h03);
    check_eq("drain_empty", {31'h0, stack_empty}, 32'h1);
    check_eq("drain_err", {31'h0, stack_err}, 32'h1);

    check_eq("queues_drained", rd_q.size() + pop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
